// File: rtl/posit_stream_bridge.sv
// Byte-serial host bridge for a posit core: command/operand loader, start/done
// launch with a timeout, and byte-wise readback of the result plus optional operand echo.
module posit_stream_bridge #(
  parameter int POSIT_W     = 16,
  parameter int N_OPS       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_in,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic                     rd_ack_i,
  output logic                     rd_ready_o,
  output logic [7:0]               data_out,
  output logic [1:0]               core_op_o,
  output logic [N_OPS*POSIT_W-1:0] core_ops_o,
  output logic                     core_start_o,
  input  logic                     core_done_i,
  input  logic [POSIT_W-1:0]       core_res_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int BYTES    = POSIT_W / 8;
  localparam int OP_BYTES = N_OPS * BYTES;
  localparam int RD_MAX   = BYTES + OP_BYTES;
  localparam int OPS_W    = N_OPS * POSIT_W;
  localparam int WP_W     = $clog2(OP_BYTES) + 1;
  localparam int RP_W     = $clog2(RD_MAX) + 1;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  localparam logic [WP_W-1:0]    WP_ONE      = WP_W'(1);
  localparam logic [WP_W-1:0]    WP_LAST     = WP_W'(OP_BYTES - 1);
  localparam logic [RP_W-1:0]    RP_ONE      = RP_W'(1);
  localparam logic [RP_W-1:0]    RP_LAST_RES = RP_W'(BYTES - 1);
  localparam logic [RP_W-1:0]    RP_LAST_DBG = RP_W'(RD_MAX - 1);
  localparam logic [CNT_W-1:0]   CNT_INIT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [POSIT_W-1:0] NAR         = {1'b1, {(POSIT_W-1){1'b0}}};

  // The read side is split into load/show/ack/release phases so that data_out
  // always settles one cycle ahead of rd_ready_o.
  typedef enum logic [2:0] {
    S_CMD,
    S_LOAD,
    S_EXEC,
    S_RD_LOAD,
    S_RD_SHOW,
    S_RD_ACK,
    S_RD_REL
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] wv_sync, ra_sync;
  logic                   wv, ra;

  logic                   wr_ready_d, rd_ready_d, start_d, err_d;
  logic                   dbg_q, dbg_d;
  logic [7:0]             data_out_d;
  logic [1:0]             op_d;
  logic [OPS_W-1:0]       ops_d;
  logic [WP_W-1:0]        wp, wp_d;
  logic [RP_W-1:0]        rp, rp_d, rp_inc, rp_last;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [POSIT_W-1:0]     res_q, res_d;
  logic [RD_MAX*8-1:0]    rd_vec;

  function automatic logic [OPS_W-1:0] put_byte(input logic [OPS_W-1:0] vec,
                                                 input logic [WP_W-1:0]  idx,
                                                 input logic [7:0]       b);
    put_byte = vec;
    for (int i = 0; i < OP_BYTES; i++) begin
      if (idx == WP_W'(i)) put_byte[i*8 +: 8] = b;
    end
  endfunction

  function automatic logic [7:0] pick_byte(input logic [RD_MAX*8-1:0] vec,
                                           input logic [RP_W-1:0]     idx);
    pick_byte = 8'h00;
    for (int i = 0; i < RD_MAX; i++) begin
      if (idx == RP_W'(i)) pick_byte = vec[i*8 +: 8];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wv_sync <= '0;
      ra_sync <= '0;
    end else begin
      wv_sync <= {wv_sync[SYNC_STAGES-2:0], wr_valid_i};
      ra_sync <= {ra_sync[SYNC_STAGES-2:0], rd_ack_i};
    end
  end

  assign wv      = wv_sync[SYNC_STAGES-1];
  assign ra      = ra_sync[SYNC_STAGES-1];
  assign busy_o  = (state != S_CMD);
  assign rd_vec  = {core_ops_o, res_q};
  assign rp_inc  = rp + RP_ONE;
  assign rp_last = dbg_q ? RP_LAST_DBG : RP_LAST_RES;

  always_comb begin
    state_d    = state;
    wr_ready_d = wr_ready_o;
    rd_ready_d = rd_ready_o;
    data_out_d = data_out;
    op_d       = core_op_o;
    ops_d      = core_ops_o;
    start_d    = 1'b0;
    err_d      = err_o;
    dbg_d      = dbg_q;
    wp_d       = wp;
    rp_d       = rp;
    cnt_d      = cnt;
    res_d      = res_q;

    case (state)
      S_CMD: begin
        if (wv && wr_ready_o) begin
          wr_ready_d = 1'b0;
          if (data_in[1:0] == 2'b11) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            op_d    = data_in[1:0];
            dbg_d   = data_in[7];
            wp_d    = '0;
            state_d = S_LOAD;
          end
        end else if (!wv && !wr_ready_o) begin
          wr_ready_d = 1'b1;
        end
      end

      S_LOAD: begin
        if (wv && wr_ready_o) begin
          wr_ready_d = 1'b0;
          ops_d      = put_byte(core_ops_o, wp, data_in);
          if (wp == WP_LAST) begin
            start_d = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_EXEC;
          end else begin
            wp_d = wp + WP_ONE;
          end
        end else if (!wv && !wr_ready_o) begin
          wr_ready_d = 1'b1;
        end
      end

      // Done is checked before the timeout so a same-cycle arrival still counts.
      S_EXEC: begin
        if (core_done_i) begin
          res_d   = core_res_i;
          rp_d    = '0;
          state_d = S_RD_LOAD;
        end else if (cnt == CNT_ONE) begin
          res_d   = NAR;
          err_d   = 1'b1;
          rp_d    = '0;
          state_d = S_RD_LOAD;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end

      S_RD_LOAD: begin
        data_out_d = pick_byte(rd_vec, rp);
        state_d    = S_RD_SHOW;
      end

      S_RD_SHOW: begin
        rd_ready_d = 1'b1;
        state_d    = S_RD_ACK;
      end

      S_RD_ACK: begin
        if (ra) begin
          rd_ready_d = 1'b0;
          state_d    = S_RD_REL;
        end
      end

      S_RD_REL: begin
        if (!ra) begin
          if (rp == rp_last) begin
            wr_ready_d = 1'b1;
            state_d    = S_CMD;
          end else begin
            rp_d       = rp_inc;
            data_out_d = pick_byte(rd_vec, rp_inc);
            state_d    = S_RD_SHOW;
          end
        end
      end

      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CMD;
      wr_ready_o   <= 1'b1;
      rd_ready_o   <= 1'b0;
      data_out     <= '0;
      core_op_o    <= '0;
      core_ops_o   <= '0;
      core_start_o <= 1'b0;
      err_o        <= 1'b0;
      dbg_q        <= 1'b0;
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      res_q        <= '0;
    end else begin
      state        <= state_d;
      wr_ready_o   <= wr_ready_d;
      rd_ready_o   <= rd_ready_d;
      data_out     <= data_out_d;
      core_op_o    <= op_d;
      core_ops_o   <= ops_d;
      core_start_o <= start_d;
      err_o        <= err_d;
      dbg_q        <= dbg_d;
      wp           <= wp_d;
      rp           <= rp_d;
      cnt          <= cnt_d;
      res_q        <= res_d;
    end
  end

endmodule

// File: tb/tb_posit_stream_bridge.sv
// Self-checking bench for posit_stream_bridge: 4-phase host model, a latency-programmable
// core model, and a transaction-level reference for readback bytes and flags.
module tb_posit_stream_bridge;

  localparam int P_W   = 16;
  localparam int N_OPS = 2;
  localparam int SYNC  = 2;
  localparam int TMO   = 4;
  localparam int BYTES = P_W / 8;
  localparam int OPB   = N_OPS * BYTES;
  localparam int OPW   = N_OPS * P_W;
  localparam logic [P_W-1:0] NAR = {1'b1, {(P_W-1){1'b0}}};

  logic           clk;
  logic           rst_n;
  logic [7:0]     data_in;
  logic           wr_valid_i;
  logic           wr_ready_o;
  logic           rd_ack_i;
  logic           rd_ready_o;
  logic [7:0]     data_out;
  logic [1:0]     core_op_o;
  logic [OPW-1:0] core_ops_o;
  logic           core_start_o;
  logic           core_done_i;
  logic [P_W-1:0] core_res_i;
  logic           busy_o;
  logic           err_o;

  int tests;
  int fails;
  int starts;
  int cyc;
  int start_cyc;
  int err_cyc;
  int remaining;
  int last_wr_lat;
  int core_lat = -1;
  bit armed = 1'b0;
  bit force_done = 1'b0;
  logic err_prev;
  logic [P_W-1:0] core_val = '0;
  logic [1:0] exp_op;

  posit_stream_bridge #(
    .POSIT_W    (P_W),
    .N_OPS      (N_OPS),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .rd_ack_i    (rd_ack_i),
    .rd_ready_o  (rd_ready_o),
    .data_out    (data_out),
    .core_op_o   (core_op_o),
    .core_ops_o  (core_ops_o),
    .core_start_o(core_start_o),
    .core_done_i (core_done_i),
    .core_res_i  (core_res_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: answers core_lat cycles after the start pulse (never if negative),
  // and timestamps start pulses and err_o rising edges.
  initial begin
    core_done_i = 1'b0;
    core_res_i  = '0;
    starts = 0; cyc = 0; start_cyc = 0; err_cyc = 0; remaining = 0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      core_done_i = force_done;
      if (force_done) core_res_i = '1;
      if (err_o === 1'b1 && err_prev !== 1'b1) err_cyc = cyc;
      err_prev = err_o;
      if (core_start_o === 1'b1) begin
        starts++;
        start_cyc = cyc;
        armed     = (core_lat >= 0);
        remaining = core_lat;
      end else if (armed) begin
        remaining--;
      end
      if (armed && remaining == 0) begin
        core_done_i = 1'b1;
        core_res_i  = core_val;
        armed       = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] b, input int hold);
    int n;
    n = 0;
    while (wr_ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests++;
    if (wr_ready_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wr_ready_idle: wr_ready_o=%b, expected 1", wr_ready_o);
    end
    data_in    = b;
    wr_valid_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (wr_ready_o !== 1'b0 && n < 100);
    last_wr_lat = n;
    tests++;
    if (wr_ready_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wr_capture: wr_ready_o=%b, expected 0", wr_ready_o);
    end
    if (hold > 0) begin
      tick(hold);
      tests++;
      if (wr_ready_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL wr_hold: wr_ready_o=%b while strobe held, expected 0", wr_ready_o);
      end
    end
    wr_valid_i = 1'b0;
    data_in    = ~b;
    tick(SYNC + 2);
  endtask

  task automatic host_read(output logic [7:0] b);
    int n;
    logic [7:0] prev;
    n = 0;
    prev = data_out;
    while (rd_ready_o !== 1'b1 && n < 200) begin
      prev = data_out;
      @(negedge clk);
      n++;
    end
    b = data_out;
    tests++;
    if (rd_ready_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rd_ready_wait: rd_ready_o=%b, expected 1", rd_ready_o);
    end
    if (n > 0) begin
      tests++;
      if (prev !== b) begin
        fails++;
        $display("[TB] FAIL data_lead: data_out one cycle before ready=%h, expected %h", prev, b);
      end
    end
    rd_ack_i = 1'b1;
    n = 0;
    while (rd_ready_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    tests++;
    if (rd_ready_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rd_ack_drop: rd_ready_o=%b, expected 0", rd_ready_o);
    end
    rd_ack_i = 1'b0;
  endtask

  // Reference: reserved opcodes only raise err; otherwise the readback is the
  // result (or NaR on timeout) LSB first, then operand bytes when bit7 is set.
  task automatic run_txn(input logic [7:0] cmd, input logic [OPW-1:0] ops,
                         input logic [P_W-1:0] res, input int lat, input int hold);
    logic [7:0]     exp_q[$];
    logic [7:0]     got;
    logic [P_W-1:0] exp_res;
    bit             timed_out;
    int             s0;
    if (cmd[1:0] == 2'b11) begin
      host_write(cmd, hold);
      tests++;
      if ({err_o, busy_o, wr_ready_o, core_op_o} !== {1'b1, 1'b0, 1'b1, exp_op}) begin
        fails++;
        $display("[TB] FAIL reserved_cmd: err/busy/ready/op=%b%b%b%b, expected 101%b",
                 err_o, busy_o, wr_ready_o, core_op_o, exp_op);
      end
      return;
    end
    core_val = res;
    core_lat = lat;
    s0 = starts;
    host_write(cmd, hold);
    exp_op = cmd[1:0];
    tests++;
    if ({busy_o, err_o, core_op_o} !== {1'b1, 1'b0, exp_op}) begin
      fails++;
      $display("[TB] FAIL cmd_accept: busy/err/op=%b%b%b, expected 10%b", busy_o, err_o, core_op_o, exp_op);
    end
    for (int i = 0; i < OPB; i++) host_write(ops[i*8 +: 8], hold);
    timed_out = (lat < 0) || (lat >= TMO);
    exp_res   = timed_out ? NAR : res;
    for (int i = 0; i < BYTES; i++) exp_q.push_back(exp_res[i*8 +: 8]);
    if (cmd[7]) for (int i = 0; i < OPB; i++) exp_q.push_back(ops[i*8 +: 8]);
    foreach (exp_q[i]) begin
      host_read(got);
      tests++;
      if (got !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL read_byte%0d: got %h, expected %h (cmd %h)", i, got, exp_q[i], cmd);
      end
    end
    tick(SYNC + 3);
    tests++;
    if ({busy_o, wr_ready_o, rd_ready_o, err_o, data_out} !== {1'b0, 1'b1, 1'b0, timed_out, exp_q[$]}) begin
      fails++;
      $display("[TB] FAIL txn_end: busy/wr/rd/err=%b%b%b%b data=%h, expected 010%b data=%h",
               busy_o, wr_ready_o, rd_ready_o, err_o, data_out, timed_out, exp_q[$]);
    end
    tests++;
    if (starts - s0 != 1) begin
      fails++;
      $display("[TB] FAIL start_pulses: got %0d cycles of core_start_o, expected 1", starts - s0);
    end
    tests++;
    if (core_ops_o !== ops) begin
      fails++;
      $display("[TB] FAIL operands: core_ops_o=%h, expected %h", core_ops_o, ops);
    end
  endtask

  task automatic test_reset();
    tick(3);
    tests++;
    if ({wr_ready_o, rd_ready_o, data_out, core_op_o, core_ops_o, core_start_o, busy_o, err_o}
        !== {1'b1, 1'b0, 8'h00, 2'b00, {OPW{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_power_up: outputs wr/rd=%b%b data=%h op=%b ops=%h start/busy/err=%b%b%b",
               wr_ready_o, rd_ready_o, data_out, core_op_o, core_ops_o, core_start_o, busy_o, err_o);
    end
    rst_n = 1'b1;
    tick(2);
    host_write(8'h82, 0);
    host_write(8'hA5, 0);
    host_write(8'h5A, 0);
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_load_busy: busy_o=%b, expected 1", busy_o);
    end
    rst_n = 1'b0;
    exp_op = 2'b00;
    tick(1);
    tests++;
    if ({wr_ready_o, rd_ready_o, data_out, core_op_o, core_ops_o, core_start_o, busy_o, err_o}
        !== {1'b1, 1'b0, 8'h00, 2'b00, {OPW{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_mid_load: outputs wr/rd=%b%b data=%h op=%b ops=%h start/busy/err=%b%b%b",
               wr_ready_o, rd_ready_o, data_out, core_op_o, core_ops_o, core_start_o, busy_o, err_o);
    end
    rst_n = 1'b1;
    tick(2);
    run_txn(8'h00, 32'h3C00_4800, 16'h4C00, 1, 0);
  endtask

  task automatic test_add();
    run_txn(8'h00, {16'h4000, 16'h4000}, 16'h5000, 3, 0);
  endtask

  task automatic test_debug_echo();
    run_txn(8'h81, {16'h5000, 16'h5000}, 16'h6000, 2, 0);
  endtask

  task automatic test_reserved();
    run_txn(8'h03, '0, '0, 0, 0);
    run_txn(8'h83, '0, '0, 0, 0);
    run_txn(8'h00, 32'h1234_ABCD, 16'h7F01, 0, 0);
  endtask

  task automatic test_timeout();
    run_txn(8'h01, 32'h0102_0304, 16'h1111, -1, 0);
    tests++;
    if (err_cyc - start_cyc != TMO) begin
      fails++;
      $display("[TB] FAIL timeout_latency: err_o rose %0d cycles after start, expected %0d",
               err_cyc - start_cyc, TMO);
    end
    run_txn(8'h02, 32'hFEDC_BA98, 16'h2222, TMO, 0);
    tests++;
    if (err_cyc - start_cyc != TMO) begin
      fails++;
      $display("[TB] FAIL timeout_late_done: err_o rose %0d cycles after start, expected %0d",
               err_cyc - start_cyc, TMO);
    end
    run_txn(8'h02, 32'h0F0F_F0F0, 16'h3333, TMO - 1, 0);
  endtask

  task automatic test_ignored_inputs();
    logic [7:0] d0;
    int s0;
    d0 = data_out;
    s0 = starts;
    force_done = 1'b1;
    rd_ack_i   = 1'b1;
    tick(SYNC + 4);
    tests++;
    if ({busy_o, rd_ready_o, err_o, data_out} !== {1'b0, 1'b0, 1'b0, d0} || starts != s0) begin
      fails++;
      $display("[TB] FAIL idle_ignore: busy/rd/err=%b%b%b data=%h starts=%0d, expected 000 data=%h starts=%0d",
               busy_o, rd_ready_o, err_o, data_out, starts, d0, s0);
    end
    force_done = 1'b0;
    rd_ack_i   = 1'b0;
    tick(SYNC + 2);
    run_txn(8'h80, 32'hCAFE_0042, 16'h0077, 1, 0);
  endtask

  task automatic test_handshake_sync();
    run_txn(8'h81, 32'h9876_5432, 16'hA1B2, 2, 20);
    tests++;
    if (last_wr_lat != SYNC + 1) begin
      fails++;
      $display("[TB] FAIL sync_latency: wr_ready_o fell %0d cycles after strobe, expected %0d",
               last_wr_lat, SYNC + 1);
    end
  endtask

  task automatic test_random();
    logic [OPW-1:0] ops;
    logic [P_W-1:0] res;
    logic [7:0]     cmd;
    int             lat;
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < OPB; j++) ops[j*8 +: 8] = 8'($urandom);
      res = P_W'($urandom);
      cmd = 8'($urandom);
      lat = int'($urandom_range(0, TMO + 1));
      run_txn(cmd, ops, res, lat, 0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_op = 2'b00;
    last_wr_lat = 0;
    rst_n = 1'b0;
    data_in = 8'h00;
    wr_valid_i = 1'b0;
    rd_ack_i = 1'b0;
    test_reset();
    test_add();
    test_debug_echo();
    test_reserved();
    test_timeout();
    test_ignored_inputs();
    test_handshake_sync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
